// File: rtl/lmc_mem_loader.sv
// Purpose : streams DEPTH program words into the LMC RAM, optionally re-reads and XOR-checks them.
// Latency : done 8 edges after the start edge with in_valid held high (13 with read-back verify).
// Backpress: in_ready is high only in LOAD; one word per two cycles, words offered elsewhere are not taken.
//
// Ports
//   clk, rst_n        : single clock, synchronous active-low reset
//   start             : begin a run (sampled only in IDLE or DONE)
//   in_data/in_valid/in_ready : program word stream from the host, valid/ready handshake
//   mem_adr/mem_din/mem_we    : registered RAM write port (write happens on the edge where mem_we=1)
//   mem_dout          : asynchronous RAM read data for mem_adr
//   busy/done/err/chk : run status, verify mismatch, XOR checksum of accepted words
//
// Build option: define LMC_LOADER_VERIFY_EN to add the VERIFY/CHECK read-back pass.
// Without it err is tied low and mem_dout is ignored.

module lmc_mem_loader #(
    parameter int AW    = 2,
    parameter int DW    = 4,
    parameter int DEPTH = 1 << AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    input  logic [DW-1:0] mem_dout,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] chk
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        WRITE  = 3'd2,
        VERIFY = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5
    } state_t;

    // Last address of a run; the counter stops here instead of wrapping.
    localparam logic [AW-1:0] LAST_ADR = AW'(DEPTH - 1);

    state_t        state;
    logic [AW-1:0] cnt;

    // The loader only takes a word while waiting in LOAD; the following
    // WRITE cycle gives the RAM one full cycle with a stable strobe.
    assign in_ready = (state == LOAD);

`ifdef LMC_LOADER_VERIFY_EN
    logic [DW-1:0] rsum;
    logic          err_q;

    assign err = err_q;
`else
    // No read-back pass: the RAM output is not observed.
    logic unused_dout;

    assign unused_dout = ^mem_dout;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            mem_adr <= '0;
            mem_din <= '0;
            mem_we  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            chk     <= '0;
`ifdef LMC_LOADER_VERIFY_EN
            rsum    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                // A finished run keeps done/err/chk until the next start,
                // and start from DONE begins a new run without a reset.
                IDLE, DONE: begin
                    if (start) begin
                        state <= LOAD;
                        cnt   <= '0;
                        chk   <= '0;
                        done  <= 1'b0;
                        busy  <= 1'b1;
`ifdef LMC_LOADER_VERIFY_EN
                        rsum  <= '0;
                        err_q <= 1'b0;
`endif
                    end
                end

                LOAD: begin
                    if (in_valid) begin
                        mem_din <= in_data;
                        mem_adr <= cnt;
                        mem_we  <= 1'b1;
                        chk     <= chk ^ in_data;
                        state   <= WRITE;
                    end else begin
                        mem_we  <= 1'b0;
                    end
                end

                // mem_we is high during this whole cycle, so the RAM takes
                // the word on the edge that leaves WRITE.
                WRITE: begin
                    mem_we <= 1'b0;
                    if (cnt == LAST_ADR) begin
`ifdef LMC_LOADER_VERIFY_EN
                        state   <= VERIFY;
                        cnt     <= '0;
                        mem_adr <= '0;
`else
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
`endif
                    end else begin
                        cnt   <= cnt + 1'b1;
                        state <= LOAD;
                    end
                end

`ifdef LMC_LOADER_VERIFY_EN
                // mem_adr is already settled at the start of each VERIFY
                // cycle, so the asynchronous read is folded in at the edge.
                VERIFY: begin
                    rsum <= rsum ^ mem_dout;
                    if (cnt == LAST_ADR) begin
                        state <= CHECK;
                    end else begin
                        cnt     <= cnt + 1'b1;
                        mem_adr <= cnt + 1'b1;
                    end
                end

                CHECK: begin
                    err_q <= (rsum != chk);
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
`endif

                default: begin
                    state  <= IDLE;
                    mem_we <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
